// File: rtl/rfft_in_loader.sv
// Input loader for the 256-point RFFT core: streams one frame into four 64-deep banks.
// Optional build macro: RFFT_LOADER_BITREV_EN (bit-reversed bank/address map).
module rfft_in_loader #(
    parameter int WIDTH  = 32,
    parameter int N      = 256,
    parameter int ADDR_W = 6
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              s_valid,
    input  logic [WIDTH-1:0]  s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic [3:0]        bank_we,
    output logic [ADDR_W-1:0] bank_addr,
    output logic [WIDTH-1:0]  bank_wdata,
    output logic              fft_start,
    input  logic              fft_done,
    output logic              busy,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] idx_q;
    logic [7:0] idx_d;
    logic       done_q;
    logic       done_edge;
    logic       accept;
    logic       last_idx;
    logic [7:0] map_k;

    assign s_ready   = (state_q == LOAD);
    assign accept    = s_valid & s_ready;
    assign last_idx  = (idx_q == 8'(N - 1));
    assign done_edge = fft_done & ~done_q;

`ifdef RFFT_LOADER_BITREV_EN
    // Decimation-in-time ordering: sample k lands at bitreverse8(k)
    function automatic logic [7:0] bitrev8(input logic [7:0] k);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = k[7-i];
        end
        return r;
    endfunction
    assign map_k = bitrev8(idx_q);
`else
    assign map_k = idx_q;
`endif

    // Next-state and index update
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    if (last_idx) begin
                        state_d = START;
                        idx_d   = 8'd0;
                    end else if (s_last) begin
                        idx_d = 8'd0;
                    end else begin
                        idx_d = idx_q + 8'd1;
                    end
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (done_edge) begin
                    state_d = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    // State, index and done-edge registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= LOAD;
            idx_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= fft_done;
        end
    end

    // Registered bank write port, start pulse, busy flag and framing error
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bank_we    <= 4'd0;
            bank_addr  <= '0;
            bank_wdata <= '0;
            fft_start  <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            bank_we   <= accept ? (4'b0001 << map_k[7:6]) : 4'd0;
            fft_start <= (state_q == START);
            frame_err <= accept & (last_idx ^ s_last);
            if (accept) begin
                bank_addr  <= map_k[5:0];
                bank_wdata <= s_data;
            end
            if (state_q == WAIT && done_edge) begin
                busy <= 1'b0;
            end else if (accept && idx_q == 8'd0) begin
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rfft_in_loader.sv
// Directed bench for rfft_in_loader: frame load, start timing, done handshake,
// framing errors, mid-frame reset and (optionally) the bit-reversed map.
module tb_rfft_in_loader;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [3:0]  bank_we;
    logic [5:0]  bank_addr;
    logic [31:0] bank_wdata;
    logic        fft_start;
    logic        fft_done = 1'b0;
    logic        busy;
    logic        frame_err;

    rfft_in_loader dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .bank_we    (bank_we),
        .bank_addr  (bank_addr),
        .bank_wdata (bank_wdata),
        .fft_start  (fft_start),
        .fft_done   (fft_done),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    always #5 Clk = ~Clk;

    int nvec = 0;
    int nerr = 0;
    int cyc = 0;
    int last_acc = 0;

    int wcount = 0;
    int nstart = 0;
    int start_cyc = -1;
    int nferr = 0;
    int ferr_cyc = -1;
    int onehot_bad = 0;

    logic [31:0] mem [4][64];
    logic [3:0]  log_we   [0:2047];
    logic [5:0]  log_addr [0:2047];
    logic [31:0] log_data [0:2047];

    always @(posedge Clk) cyc <= cyc + 1;

    // Observe the bank port and pulses on the falling edge
    always @(negedge Clk) begin
        if (bank_we != 4'd0) begin
            if (wcount < 2048) begin
                log_we[wcount]   <= bank_we;
                log_addr[wcount] <= bank_addr;
                log_data[wcount] <= bank_wdata;
            end
            wcount <= wcount + 1;
            if (!$onehot(bank_we)) onehot_bad <= onehot_bad + 1;
            for (int b = 0; b < 4; b++) begin
                if (bank_we[b]) mem[b][bank_addr] <= bank_wdata;
            end
        end
        if (fft_start) begin
            nstart    <= nstart + 1;
            start_cyc <= cyc;
        end
        if (frame_err) begin
            nferr    <= nferr + 1;
            ferr_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        nvec++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic last, input logic [31:0] d);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(posedge Clk);
        #1;
        last_acc = cyc;
        s_valid  = 1'b0;
        s_last   = 1'b0;
    endtask

    task automatic pulse_done();
        fft_done = 1'b1;
        tick(1);
        fft_done = 1'b0;
    endtask

    function automatic logic [7:0] tmap(input int k);
        logic [7:0] v;
        logic [7:0] r;
        v = k[7:0];
        r = v;
`ifdef RFFT_LOADER_BITREV_EN
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
`endif
        return r;
    endfunction

    function automatic int mem_bad(input logic [31:0] base);
        int bad;
        logic [7:0] m;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            m = tmap(k);
            if (mem[m[7:6]][m[5:0]] !== base + 32'(k)) bad++;
        end
        return bad;
    endfunction

    int w0;
    int s0;
    int f0;

    initial begin
        tick(2);
        Reset = 1'b0;
        chk("rst_ready", s_ready, 1);
        chk("rst_we", bank_we, 0);
        chk("rst_start", fft_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);

        // Frame 1: back-to-back, data = k
        w0 = wcount;
        for (int k = 0; k < 256; k++) send(k == 255, 32'(k));
        tick(4);
        chk("f1_writes", wcount - w0, 256);
        chk("f1_mem", mem_bad(32'd0), 0);
        chk("f1_nstart", nstart, 1);
        chk("f1_start_t", start_cyc, last_acc + 1);
        chk("f1_ready", s_ready, 0);
        chk("f1_busy", busy, 1);
        chk("f1_ferr", nferr, 0);
        chk("f1_onehot", onehot_bad, 0);
        chk("k70_data", log_data[w0+70], 70);
`ifdef RFFT_LOADER_BITREV_EN
        chk("k70_we", log_we[w0+70], 4'b0010);
        chk("k70_addr", log_addr[w0+70], 34);
        chk("k1_we", log_we[w0+1], 4'b0100);
        chk("k1_addr", log_addr[w0+1], 0);
        chk("k3_we", log_we[w0+3], 4'b1000);
        chk("k3_addr", log_addr[w0+3], 0);
`else
        chk("k70_we", log_we[w0+70], 4'b0010);
        chk("k70_addr", log_addr[w0+70], 6);
`endif

        // Done handshake, then frame 2 with random gaps
        tick(3);
        chk("wait_ready", s_ready, 0);
        pulse_done();
        chk("done_ready", s_ready, 1);
        chk("done_busy", busy, 0);
        w0 = wcount;
        s0 = nstart;
        for (int k = 0; k < 256; k++) begin
            send(k == 255, 32'h1000 + 32'(k));
            if (k == 0) begin
                tick(1);
                chk("f2_k0_we", log_we[w0], 4'b0001);
                chk("f2_k0_addr", log_addr[w0], 0);
                chk("f2_busy", busy, 1);
            end
            if (k != 255) tick($urandom_range(0, 5));
        end
        tick(4);
        chk("f2_writes", wcount - w0, 256);
        chk("f2_mem", mem_bad(32'h1000), 0);
        chk("f2_nstart", nstart - s0, 1);
        chk("f2_start_t", start_cyc, last_acc + 1);
        pulse_done();

        // Early s_last at k=99
        w0 = wcount;
        s0 = nstart;
        f0 = nferr;
        for (int k = 0; k < 100; k++) send(k == 99, 32'h2000 + 32'(k));
        tick(4);
        chk("early_ferr", nferr - f0, 1);
        chk("early_ferr_t", ferr_cyc, last_acc);
        chk("early_nostart", nstart - s0, 0);
        chk("early_ready", s_ready, 1);
        chk("early_writes", wcount - w0, 100);
        send(1'b0, 32'h55);
        tick(1);
        chk("early_nx_we", log_we[w0+100], 4'b0001);
        chk("early_nx_addr", log_addr[w0+100], 0);
        chk("early_nx_data", log_data[w0+100], 32'h55);

        // Missing s_last at k=255
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        chk("rst2_ready", s_ready, 1);
        chk("rst2_busy", busy, 0);
        s0 = nstart;
        f0 = nferr;
        for (int k = 0; k < 256; k++) send(1'b0, 32'h3000 + 32'(k));
        tick(4);
        chk("nolast_ferr", nferr - f0, 1);
        chk("nolast_ferr_t", ferr_cyc, last_acc);
        chk("nolast_nstart", nstart - s0, 1);
        chk("nolast_start_t", start_cyc, last_acc + 1);
        chk("nolast_mem", mem_bad(32'h3000), 0);
        pulse_done();

        // Reset partway through the next frame
        s0 = nstart;
        for (int k = 0; k < 128; k++) send(1'b0, 32'h4000 + 32'(k));
        Reset = 1'b1;
        tick(1);
        Reset = 1'b0;
        chk("mid_ready", s_ready, 1);
        chk("mid_busy", busy, 0);
        chk("mid_we", bank_we, 0);
        tick(5);
        chk("mid_nostart", nstart - s0, 0);
        w0 = wcount;
        send(1'b0, 32'h77);
        tick(1);
        chk("mid_nx_we", log_we[w0], 4'b0001);
        chk("mid_nx_addr", log_addr[w0], 0);
        chk("mid_nx_data", log_data[w0], 32'h77);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
